// File: rtl/alu_muldiv.sv
// alu_muldiv: execute-stage ALU with single-cycle ops plus iterative MULT/DIV
// writing architectural HI/LO. Build option ALU_MULDIV_DIV_EN compiles in the
// divider; without it op 11101 behaves as an unknown single-cycle op (result 0).
module alu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic             sign,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);
  localparam int unsigned CNT_W   = $clog2(WIDTH);
  localparam int unsigned PW      = 2 * WIDTH;

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SLT  = 5'b00111;
  localparam logic [4:0] OP_NOR  = 5'b01100;
  localparam logic [4:0] OP_XOR  = 5'b01101;
  localparam logic [4:0] OP_SLL  = 5'b10000;
  localparam logic [4:0] OP_SRL  = 5'b11000;
  localparam logic [4:0] OP_SRA  = 5'b11001;
  localparam logic [4:0] OP_MUL  = 5'b11010;
  localparam logic [4:0] OP_MULT = 5'b11100;
  localparam logic [4:0] OP_MFHI = 5'b11110;
  localparam logic [4:0] OP_MFLO = 5'b11111;
`ifdef ALU_MULDIV_DIV_EN
  localparam logic [4:0] OP_DIV  = 5'b11101;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_FIX = 2'd3} state_e;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             neg1_q, neg1_d;
  logic             neg2_q, neg2_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
`ifdef ALU_MULDIV_DIV_EN
  logic [WIDTH-1:0] b_q, b_d;
  logic             is_div_q, is_div_d;
  logic             dz_q, dz_d;
`endif

  logic [SHAMT_W-1:0] shamt_c;
  logic               slt_c;
  logic [WIDTH-1:0]   alu_c;
  logic               neg1_c, neg2_c;
  logic [WIDTH-1:0]   mag1_c, mag2_c;
  logic [WIDTH:0]     mul_sum_c;
  logic [PW-1:0]      mul_next_c;
  logic [PW-1:0]      prod_fix_c;
`ifdef ALU_MULDIV_DIV_EN
  logic [WIDTH:0]     div_sh_c;
  logic               div_ge_c;
  logic [WIDTH-1:0]   div_diff_c;
  logic [PW-1:0]      div_next_c;
  logic [WIDTH-1:0]   quot_c, rem_c;
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

  // Single-cycle result, operand sign/magnitude conversion at accept.
  always_comb begin
    shamt_c = in1[SHAMT_W-1:0];
    slt_c   = sign ? ($signed(in1) < $signed(in2)) : (in1 < in2);
    neg1_c  = sign & in1[WIDTH-1];
    neg2_c  = sign & in2[WIDTH-1];
    mag1_c  = neg1_c ? -in1 : in1;
    mag2_c  = neg2_c ? -in2 : in2;
    alu_c   = '0;
    case (op)
      OP_AND:  alu_c = in1 & in2;
      OP_OR:   alu_c = in1 | in2;
      OP_ADD:  alu_c = in1 + in2;
      OP_SUB:  alu_c = in1 - in2;
      OP_NOR:  alu_c = ~(in1 | in2);
      OP_XOR:  alu_c = in1 ^ in2;
      OP_SLT:  alu_c = {{(WIDTH-1){1'b0}}, slt_c};
      OP_SLL:  alu_c = in2 << shamt_c;
      OP_SRL:  alu_c = in2 >> shamt_c;
      OP_SRA:  alu_c = WIDTH'($signed(in2) >>> shamt_c);
      OP_MUL:  alu_c = WIDTH'(in1 * in2);
      OP_MFHI: alu_c = hi_q;
      OP_MFLO: alu_c = lo_q;
      default: alu_c = '0;
    endcase
  end

  // Iteration datapaths: shift-add multiply and restoring divide share p_q.
  always_comb begin
    mul_sum_c  = {1'b0, p_q[PW-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    mul_next_c = {mul_sum_c, p_q[WIDTH-1:1]};
    prod_fix_c = (neg1_q ^ neg2_q) ? -p_q : p_q;
`ifdef ALU_MULDIV_DIV_EN
    div_sh_c   = p_q[PW-1:WIDTH-1];
    div_ge_c   = (div_sh_c >= {1'b0, b_q});
    div_diff_c = WIDTH'(div_sh_c - {1'b0, b_q});
    div_next_c = div_ge_c ? {div_diff_c, p_q[WIDTH-2:0], 1'b1} : {p_q[PW-2:0], 1'b0};
    quot_c     = (neg1_q ^ neg2_q) ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    rem_c      = neg1_q ? -p_q[PW-1:WIDTH] : p_q[PW-1:WIDTH];
`endif
  end

  // Next-state and register updates for the control FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    a_d         = a_q;
    neg1_d      = neg1_q;
    neg2_d      = neg2_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    hi_d        = hi_q;
    lo_d        = lo_q;
`ifdef ALU_MULDIV_DIV_EN
    b_d         = b_q;
    is_div_d    = is_div_q;
    dz_d        = dz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          case (op)
            OP_MULT: begin
              state_d = S_MUL;
              cnt_d   = '0;
              a_d     = mag1_c;
              p_d     = {{WIDTH{1'b0}}, mag2_c};
              neg1_d  = neg1_c;
              neg2_d  = neg2_c;
`ifdef ALU_MULDIV_DIV_EN
              is_div_d = 1'b0;
              dz_d     = 1'b0;
`endif
            end
`ifdef ALU_MULDIV_DIV_EN
            OP_DIV: begin
              state_d  = S_DIV;
              cnt_d    = '0;
              a_d      = mag1_c;
              b_d      = mag2_c;
              p_d      = {{WIDTH{1'b0}}, mag1_c};
              neg1_d   = neg1_c;
              neg2_d   = neg2_c;
              is_div_d = 1'b1;
              dz_d     = (in2 == '0);
            end
`endif
            default: begin
              out_d       = alu_c;
              out_valid_d = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        p_d   = mul_next_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
`ifdef ALU_MULDIV_DIV_EN
      S_DIV: begin
        p_d   = div_next_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
`endif
      S_FIX: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b1;
`ifdef ALU_MULDIV_DIV_EN
        if (is_div_q) begin
          if (dz_q) begin
            lo_d = '1;
            hi_d = neg1_q ? -a_q : a_q;
          end else begin
            lo_d = quot_c;
            hi_d = rem_c;
          end
          out_d = dz_q ? '1 : quot_c;
        end else begin
          hi_d  = prod_fix_c[PW-1:WIDTH];
          lo_d  = prod_fix_c[WIDTH-1:0];
          out_d = prod_fix_c[WIDTH-1:0];
        end
`else
        hi_d  = prod_fix_c[PW-1:WIDTH];
        lo_d  = prod_fix_c[WIDTH-1:0];
        out_d = prod_fix_c[WIDTH-1:0];
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      a_q         <= '0;
      neg1_q      <= 1'b0;
      neg2_q      <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
`ifdef ALU_MULDIV_DIV_EN
      b_q         <= '0;
      is_div_q    <= 1'b0;
      dz_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      a_q         <= a_d;
      neg1_q      <= neg1_d;
      neg2_q      <= neg2_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
`ifdef ALU_MULDIV_DIV_EN
      b_q         <= b_d;
      is_div_q    <= is_div_d;
      dz_q        <= dz_d;
`endif
    end
  end

endmodule
